// File: rtl/vga_text_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_pkg
//  Description : Shared constants and types for the VGA text console path:
//                screen geometry, VRAM layout, control codes, FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_text_pkg;

    localparam int unsigned COLS          = 80;
    localparam int unsigned ROWS          = 30;
    localparam int unsigned WORDS_PER_ROW = 20;
    localparam int unsigned VRAM_WORDS    = 600;
    localparam int unsigned CTRL_REG      = 600;

    localparam logic [6:0] LF_CODE = 7'h0A;
    localparam logic [6:0] CR_CODE = 7'h0D;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PUT       = 3'd1,
        SCR_RD    = 3'd2,
        SCR_RDW   = 3'd3,
        SCR_WR    = 3'd4,
        SCR_BLANK = 3'd5,
        CLR       = 3'd6
    } console_state_t;

endpackage
`default_nettype wire

// File: rtl/text_console_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : text_console_writer_if
//  Description : Character stream, Avalon-MM master bus and cursor status
//                of the text console writer. "master" is the writer's view,
//                "slave" is the view of the feeder / VRAM side.
//  Revision    : 1.0  initial release
// ============================================================================
interface text_console_writer_if;

    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        clear;
    logic [9:0]  m_addr;
    logic        m_write;
    logic        m_read;
    logic [3:0]  m_byte_en;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    modport master (
        input  ch_valid, ch_data, clear, m_readdata,
        output ch_ready, m_addr, m_write, m_read, m_byte_en, m_writedata,
               cur_col, cur_row, busy
    );

    modport slave (
        output ch_valid, ch_data, clear, m_readdata,
        input  ch_ready, m_addr, m_write, m_read, m_byte_en, m_writedata,
               cur_col, cur_row, busy
    );

endinterface
`default_nettype wire

// File: rtl/text_cursor.sv
`default_nettype none
// ============================================================================
//  Module      : text_cursor
//  Description : Cursor column/row registers with advance, line wrap, CR,
//                newline and home. Flags when a row advance would fall off
//                the bottom row so the caller can scroll instead.
//  Revision    : 1.0  initial release
// ============================================================================
module text_cursor
    import vga_text_pkg::*;
#(
    parameter int unsigned COLS = vga_text_pkg::COLS,
    parameter int unsigned ROWS = vga_text_pkg::ROWS
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       inc,
    input  wire logic       newline,
    input  wire logic       cr,
    input  wire logic       home,
    output logic [6:0]      col,
    output logic [4:0]      row,
    output logic            scroll_req
);

    localparam logic [6:0] C_LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] C_LAST_ROW = 5'(ROWS - 1);

    logic w_at_last_col;
    logic w_row_adv;

    assign w_at_last_col = (col == C_LAST_COL);
    assign w_row_adv     = newline || (inc && w_at_last_col);
    // On the bottom row the row stays put and the screen scrolls instead.
    assign scroll_req    = w_row_adv && (row == C_LAST_ROW);

    // Cursor update: home beats newline beats CR beats character advance.
    always_ff @(posedge clk) begin
        if (reset || home) begin
            col <= 7'd0;
            row <= 5'd0;
        end else if (newline) begin
            col <= 7'd0;
            if (row != C_LAST_ROW) row <= row + 5'd1;
        end else if (cr) begin
            col <= 7'd0;
        end else if (inc) begin
            if (w_at_last_col) begin
                col <= 7'd0;
                if (row != C_LAST_ROW) row <= row + 5'd1;
            end else begin
                col <= col + 7'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/text_console_writer.sv
`default_nettype none
// ============================================================================
//  Module      : text_console_writer
//  Description : Turns a character byte stream into Avalon-MM byte writes to
//                the 80x30 text VRAM. Handles LF/CR, wrap, hardware scroll
//                (read/copy rows up, blank last row) and full-screen clear.
//                The control register word is never addressed.
//  Revision    : 1.0  initial release
// ============================================================================
module text_console_writer
    import vga_text_pkg::*;
#(
    parameter int unsigned COLS          = vga_text_pkg::COLS,
    parameter int unsigned ROWS          = vga_text_pkg::ROWS,
    parameter int unsigned WORDS_PER_ROW = vga_text_pkg::WORDS_PER_ROW
) (
    input  wire logic               clk,
    input  wire logic               reset,
    text_console_writer_if.master   bus
);

    localparam logic [9:0] C_ROW_WORDS   = 10'(WORDS_PER_ROW);
    localparam logic [9:0] C_SCROLL_LAST = 10'((ROWS - 1) * WORDS_PER_ROW - 1);
    localparam logic [9:0] C_LAST_WORD   = 10'(ROWS * WORDS_PER_ROW - 1);

    console_state_t r_state, w_next;

    logic [7:0]  r_char;
    logic [9:0]  r_cnt;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_is_lf;
    logic        w_is_cr;
    logic        w_inc, w_newline, w_cr, w_home;
    logic        w_scroll_req;
    logic [6:0]  w_col;
    logic [4:0]  w_row;
    logic [9:0]  w_put_addr;

    logic [9:0]  w_addr;
    logic        w_write, w_read;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign bus.ch_ready = (r_state == IDLE) && !bus.clear && !reset;
    assign w_accept     = bus.ch_valid && bus.ch_ready;
    assign w_is_lf      = (r_char[6:0] == LF_CODE);
    assign w_is_cr      = (r_char[6:0] == CR_CODE);
    assign w_put_addr   = 10'(w_row * C_ROW_WORDS) + {5'd0, w_col[6:2]};

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk        (clk),
        .reset      (reset),
        .inc        (w_inc),
        .newline    (w_newline),
        .cr         (w_cr),
        .home       (w_home),
        .col        (w_col),
        .row        (w_row),
        .scroll_req (w_scroll_req)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Latched character, word counter for scroll/clear, and scroll read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_char  <= 8'd0;
            r_cnt   <= 10'd0;
            r_rdata <= 32'd0;
        end else begin
            if (w_accept) r_char <= bus.ch_data;
            case (r_state)
                IDLE, PUT:               r_cnt   <= 10'd0;
                SCR_RDW:                 r_rdata <= bus.m_readdata;
                SCR_WR, SCR_BLANK, CLR:  r_cnt   <= r_cnt + 10'd1;
                default:                 ;
            endcase
        end
    end

    // Next state, bus strobes and cursor controls.
    always_comb begin
        w_next    = r_state;
        w_addr    = 10'd0;
        w_write   = 1'b0;
        w_read    = 1'b0;
        w_be      = 4'd0;
        w_wdata   = 32'd0;
        w_inc     = 1'b0;
        w_newline = 1'b0;
        w_cr      = 1'b0;
        w_home    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.clear)     w_next = CLR;
                else if (w_accept) w_next = PUT;
            end
            PUT: begin
                if (w_is_lf) begin
                    w_newline = 1'b1;
                end else if (w_is_cr) begin
                    w_cr = 1'b1;
                end else begin
                    w_write = 1'b1;
                    w_addr  = w_put_addr;
                    w_be    = 4'b0001 << w_col[1:0];
                    w_wdata = {4{r_char}};
                    w_inc   = 1'b1;
                end
                w_next = w_scroll_req ? SCR_RD : IDLE;
            end
            SCR_RD: begin
                w_read = 1'b1;
                w_addr = r_cnt + C_ROW_WORDS;
                w_next = SCR_RDW;
            end
            SCR_RDW: begin
                w_read = 1'b1;
                w_addr = r_cnt + C_ROW_WORDS;
                w_next = SCR_WR;
            end
            SCR_WR: begin
                w_write = 1'b1;
                w_addr  = r_cnt;
                w_be    = 4'hF;
                w_wdata = r_rdata;
                w_next  = (r_cnt == C_SCROLL_LAST) ? SCR_BLANK : SCR_RD;
            end
            SCR_BLANK: begin
                w_write = 1'b1;
                w_addr  = r_cnt;
                w_be    = 4'hF;
                if (r_cnt == C_LAST_WORD) w_next = IDLE;
            end
            CLR: begin
                w_write = 1'b1;
                w_addr  = r_cnt;
                w_be    = 4'hF;
                if (r_cnt == C_LAST_WORD) begin
                    w_home = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.m_addr      = w_addr;
    assign bus.m_write     = w_write;
    assign bus.m_read      = w_read;
    assign bus.m_byte_en   = w_be;
    assign bus.m_writedata = w_wdata;
    assign bus.cur_col     = w_col;
    assign bus.cur_row     = w_row;
    assign bus.busy        = (r_state != IDLE);

endmodule
`default_nettype wire
